serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 Port: busy  output  1  high while in RUN or DONE.
REQ-008 Port: done  output  1  one-cycle pulse; result valid.
REQ-009 Port: diff  output  WIDTH  result a-b modulo 2^WIDTH; held until the next accepted start.
REQ-010 Port: borrow  output  1  final borrow-out; high when unsigned a < b.
REQ-011 Port: ovf  output  1  signed overflow flag; present only per REQ-026.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at edge k: capture a and b into shift registers, clear the internal borrow flop, clear the bit counter, go to RUN.
REQ-014 RUN, one bit per edge, LSB first: d = a_i ^ b_i ^ bin; bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin).
REQ-015 Each d SHALL shift into the result register from the MSB end, so that after WIDTH bits diff[i] holds bit i.
REQ-016 The transition RUN->DONE SHALL occur on edge k+WIDTH, after which done=1, busy=1, and diff/borrow are final.
REQ-017 The transition DONE->IDLE SHALL occur unconditionally on edge k+WIDTH+1, after which done=0 and busy=0.
REQ-018 Latency: start accepted at edge k gives done high for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
REQ-019 start SHALL be ignored in RUN and DONE; in those states changes on a and b SHALL NOT affect the result.
REQ-020 diff and borrow SHALL change only during RUN, and otherwise hold the last completed result.
REQ-021 start held high continuously SHALL begin a new operation every WIDTH+2 cycles.
REQ-022 Operands a=b SHALL produce diff=0 and borrow=0.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, counter=0, and clear both shift registers.
REQ-024 Reset asserted in RUN or DONE SHALL abort the operation without a done pulse.
REQ-025 After rst_n deasserts, the first start sampled high on a rising edge SHALL be accepted.

Configuration
REQ-026 With macro SERIAL_SUB_OVF_EN defined, port ovf SHALL exist and be set on edge k+WIDTH to (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands; it holds like diff and clears on reset.
REQ-027 Without SERIAL_SUB_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 WIDTH=8, a=5, b=3, start pulse at edge k -> done high after edge k+8, diff=8'h02, borrow=0, ovf=0.
REQ-029 a=3, b=5 -> diff=8'hFE, borrow=1, ovf=0.
REQ-030 a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1 (macro defined); port absent and result identical without the macro.
REQ-031 Accept a=9, b=4, then during RUN pulse start with a=0, b=1 -> single done pulse, diff=8'h05; the second start is not executed.
REQ-032 Drop rst_n low at edge k+4 of an operation -> busy, done, and diff go to 0 immediately, and no done pulse follows; a new start after release gives the correct result.
REQ-033 start held high, a=8'hFF, b=8'hFF -> done pulses every 10 cycles, diff=0, borrow=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b subtractor, LSB first, one bit per clock
// Optional signed-overflow flag and port enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic             a_i, b_i, d, bout, last;

  // Full-subtractor cell on the current low bits of the operand shifters.
  always_comb begin
    a_i  = a_sr[0];
    b_i  = b_sr[0];
    d    = a_i ^ b_i ^ bin;
    bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin);
    last = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            bin  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bin  <= bout;
          cnt  <= cnt + CW'(1);
          // Result fills from the MSB end so bit i lands at diff[i] after WIDTH shifts.
          diff <= {d, diff[WIDTH-1:1]};
          if (last) begin
            borrow <= bout;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit a_i/b_i are the captured operand sign bits and d is diff's MSB.
            ovf <= (a_i != b_i) && (d != a_i);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_pass = 0;
  int n_tot  = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // Reference: arithmetic result plus a cycle count since acceptance (-1 = idle).
  int           m_cyc;
  logic [W-1:0] m_diff, p_diff;
  logic         m_borrow, p_borrow, m_ovf, p_ovf;

  function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    r  = sx - sy;
    return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc    <= -1;
      m_diff   <= '0;
      m_borrow <= 1'b0;
      m_ovf    <= 1'b0;
    end else if (m_cyc < 0) begin
      if (start) begin
        m_cyc    <= 0;
        p_diff   <= a - b;
        p_borrow <= (a < b);
        p_ovf    <= signed_ovf(a, b);
      end
    end else if (m_cyc == W) begin
      m_cyc <= -1;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc + 1 == W) begin
        m_diff   <= p_diff;
        m_borrow <= p_borrow;
        m_ovf    <= p_ovf;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string nm);
    int n;
    @(posedge clk);
    #1 a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    check({nm, ":latency"}, n, W + 1);
    check({nm, ":diff"}, diff, ed);
    check({nm, ":borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
    check({nm, ":ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unexpected x");
`endif
  endtask

  initial begin
    int ndone, last_i, cnt;
    logic [W-1:0] seen;

    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          check("mon_busy", busy, m_cyc >= 0);
          check("mon_done", done, m_cyc == W);
          if (m_cyc < 0 || m_cyc == W) begin
            check("mon_diff", diff, m_diff);
            check("mon_borrow", borrow, m_borrow);
`ifdef SERIAL_SUB_OVF_EN
            check("mon_ovf", ovf, m_ovf);
`endif
          end
        end
      end
    join_none

    start = 1'b0; a = '0; b = '0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    run_op(8'd5,  8'd3,  8'h02, 1'b0, 1'b0, "5-3");
    run_op(8'd3,  8'd5,  8'hFE, 1'b1, 1'b0, "3-5");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "80-01");
    run_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, "a_eq_b");
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "00-FF");
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "7F-FF");

    // Start during RUN with new operands must be ignored.
    @(posedge clk);
    #1 a = 8'd9; b = 8'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; a = 8'd0; b = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin ndone++; seen = diff; end
    end
    check("ign_start:pulses", ndone, 1);
    check("ign_start:diff", seen, 8'h05);

    // Reset mid-operation aborts without a done pulse.
    @(posedge clk);
    #1 a = 8'h33; b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, "after_abort");

    // start held high: a new operation every W+2 cycles.
    @(posedge clk);
    #1 a = 8'hFF; b = 8'hFF; start = 1'b1;
    ndone = 0; last_i = -1; cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("hold:diff", diff, 8'h00);
        check("hold:borrow", borrow, 1'b0);
        if (last_i >= 0) check("hold:period", i - last_i, 10);
        last_i = i;
      end
    end
    check("hold:pulses", ndone, 4);
    #1 start = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("hold:idle", busy, 0);
    repeat (2) @(negedge clk);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
